// File: rtl/slow_tick_timer_if.sv
// Command/status bundle between the elevator controller and the slow tick timer.
// The controller (master) issues start/abort with a duration.
// The timer (slave) reports busy, ticks remaining and a done pulse.
interface slow_tick_timer_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] load_val;
    logic             abort;
    logic             busy;
    logic [CNT_W-1:0] remaining;
    logic             done;

    modport master (
        output start, load_val, abort,
        input  busy, remaining, done
    );

    modport slave (
        input  start, load_val, abort,
        output busy, remaining, done
    );
endinterface

// File: rtl/slow_tick_timer.sv
// Slow tick timer: synchronises the divided slow clock level (tick_in) into clk.
// Each rising edge of tick_in becomes a one-cycle tick_pulse.
// The start/abort/done timer counts load_val of those pulses.
module slow_tick_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick_in,
    output logic             tick_pulse,
    slow_tick_timer_if.slave tif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last;
    logic                   prev_q;
    logic [CNT_W-1:0]       remaining_q, remaining_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Synchronise tick_in, remember the previous level, emit a gated rising-edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            tick_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], tick_in};
            prev_q     <= sync_last;
            tick_pulse <= en & sync_last & ~prev_q;
        end
    end

    // Timer state and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: abort beats start and tick; a tick with frozen en never arrives
    // because tick_pulse is already gated low.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (tif.start && !tif.abort) begin
                    if (tif.load_val == '0) begin
                        state_d     = DONE;
                        remaining_d = '0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d     = RUN;
                        remaining_d = tif.load_val;
                        busy_d      = 1'b1;
                    end
                end
            end
            RUN: begin
                if (tif.abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                    busy_d      = 1'b0;
                end else if (tick_pulse) begin
                    if (remaining_q > CNT_W'(1)) begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end else begin
                        state_d     = DONE;
                        remaining_d = '0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
                busy_d      = 1'b0;
            end
        endcase
    end

    assign tif.busy      = busy_q;
    assign tif.remaining = remaining_q;
    assign tif.done      = done_q;
endmodule

// File: tb/tb_slow_tick_timer.sv
// Bench for slow_tick_timer: directed elevator-timer scenarios with a cycle-level
// reference model and hand-computed checkpoints.
module tb_slow_tick_timer;
    localparam int S  = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic tick_in;
    logic tick_pulse;

    slow_tick_timer_if #(.CNT_W(CW)) tif ();

    slow_tick_timer #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tick_in    (tick_in),
        .tick_pulse (tick_pulse),
        .tif        (tif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit run_cmp = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model. h[i] holds tick_in as sampled i+1 edges ago, so a pulse appears
    // after edge n when tick_in was 1 at edge n-S and 0 at edge n-S-1 (and en at edge n).
    logic h [0:S];
    logic m_pulse;
    logic m_busy;
    logic m_done;
    int   m_rem;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= S; i++) h[i] <= 1'b0;
            m_pulse <= 1'b0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_rem   <= 0;
        end else begin
            h[0] <= tick_in;
            for (int i = 1; i <= S; i++) h[i] <= h[i-1];
            m_pulse <= en & h[S-1] & ~h[S];
            if (m_done) begin
                m_done <= 1'b0;
            end else if (!m_busy) begin
                if (tif.start && !tif.abort) begin
                    if (tif.load_val == 0) m_done <= 1'b1;
                    else begin
                        m_busy <= 1'b1;
                        m_rem  <= int'(tif.load_val);
                    end
                end
            end else if (tif.abort) begin
                m_busy <= 1'b0;
                m_rem  <= 0;
            end else if (m_pulse) begin
                if (m_rem == 1) begin
                    m_rem  <= 0;
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_rem <= m_rem - 1;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            check("cyc_pulse", tick_pulse, m_pulse);
            check("cyc_busy", tif.busy, m_busy);
            check("cyc_done", tif.done, m_done);
            check("cyc_rem", tif.remaining, m_rem);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_hi();
        tick_in = 1'b1;
        step(4);
    endtask

    task automatic tick_lo();
        tick_in = 1'b0;
        step(4);
    endtask

    task automatic do_start(input int val);
        tif.load_val = CW'(val);
        tif.start    = 1'b1;
        step(1);
        tif.start    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int first;
        rst          = 1'b0;
        en           = 1'b1;
        tick_in      = 1'b0;
        tif.start    = 1'b0;
        tif.abort    = 1'b0;
        tif.load_val = '0;
        step(3);
        check("rst_busy", tif.busy, 0);
        check("rst_rem", tif.remaining, 0);
        check("rst_done", tif.done, 0);
        check("rst_pulse", tick_pulse, 0);
        #2 rst = 1'b1;
        run_cmp = 1'b1;
        step(2);

        // T2: one pulse per rising edge, SYNC_STAGES+1 negedges after drive
        tick_in = 1'b1;
        n = 0;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (tick_pulse === 1'b1) begin
                n++;
                if (first == 0) first = i;
            end
        end
        check("edge_count", n, 1);
        check("edge_delay", first, 3);
        tick_in = 1'b0;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (tick_pulse === 1'b1) n++;
        end
        check("fall_nopulse", n, 0);

        // T3: count three ticks
        do_start(3);
        check("cnt_busy", tif.busy, 1);
        check("cnt_rem3", tif.remaining, 3);
        tick_hi();
        check("cnt_rem2", tif.remaining, 2);
        tick_lo();
        tick_hi();
        check("cnt_rem1", tif.remaining, 1);
        tick_lo();
        tick_hi();
        check("cnt_done", tif.done, 1);
        check("cnt_rem0", tif.remaining, 0);
        check("cnt_idle", tif.busy, 0);
        step(1);
        check("cnt_done_1cyc", tif.done, 0);
        tick_lo();

        // T4: zero duration
        do_start(0);
        check("zero_done", tif.done, 1);
        check("zero_busy", tif.busy, 0);
        check("zero_rem", tif.remaining, 0);
        step(1);
        check("zero_done_off", tif.done, 0);

        // T5: abort coinciding with a tick
        do_start(5);
        tick_hi();
        tick_lo();
        tick_hi();
        tick_lo();
        check("abort_rem3", tif.remaining, 3);
        tick_in = 1'b1;
        step(3);
        check("abort_pulse_now", tick_pulse, 1);
        tif.abort = 1'b1;
        step(1);
        tif.abort = 1'b0;
        check("abort_busy", tif.busy, 0);
        check("abort_rem", tif.remaining, 0);
        check("abort_nodone", tif.done, 0);
        tick_lo();
        check("abort_nodone_late", tif.done, 0);
        tif.abort = 1'b1;
        do_start(5);
        tif.abort = 1'b0;
        check("abort_start_idle", tif.busy, 0);
        check("abort_start_rem", tif.remaining, 0);
        step(2);

        // T6: en gating, start ignored while running
        do_start(4);
        check("gate_rem4", tif.remaining, 4);
        en = 1'b0;
        tick_hi();
        tick_lo();
        tick_hi();
        tick_lo();
        check("gate_hold", tif.remaining, 4);
        en = 1'b1;
        do_start(9);
        check("gate_noreload", tif.remaining, 4);
        check("gate_busy", tif.busy, 1);
        tick_hi();
        tick_lo();
        tick_hi();
        tick_lo();
        tick_hi();
        tick_lo();
        check("gate_rem1", tif.remaining, 1);
        tick_hi();
        check("gate_done", tif.done, 1);
        tick_lo();

        // T1: asynchronous reset in the middle of a run
        do_start(3);
        check("mid_rem3", tif.remaining, 3);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", tif.busy, 0);
        check("mid_rst_rem", tif.remaining, 0);
        check("mid_rst_done", tif.done, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        step(2);
        check("post_rst_idle", tif.busy, 0);
        do_start(1);
        check("post_rst_start", tif.remaining, 1);
        tick_hi();
        check("post_rst_done", tif.done, 1);
        tick_lo();

        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
